// File: rtl/pcileech_perst_ctl_pkg.sv
// Shared types for the PCIe sideband conditioning block.
// State encoding and timing constants.
package pcileech_perst_ctl_pkg;

  typedef enum logic [2:0] {
    S_RESET,
    S_HOLD,
    S_DETECT,
    S_RUN,
    S_OFF
  } perst_state_t;

  localparam int TICKS_PER_MS = 125_000;

endpackage

// File: rtl/pcileech_perst_debounce.sv
// Synchroniser plus consecutive-cycle debouncer for one async input.
// The filtered value moves only after DEBOUNCE_TICKS differing cycles.
module pcileech_perst_debounce #(
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;

  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], din};
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_TICKS == 0) begin : g_bypass
      assign dout = w_sync;
    end else begin : g_filt
      localparam int W = $clog2(DEBOUNCE_TICKS + 1);
      logic [W-1:0] r_cnt;
      logic         r_filt;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt  <= '0;
          r_filt <= 1'b0;
        end else if (w_sync == r_filt) begin
          r_cnt <= '0;
        end else if (r_cnt == W'(DEBOUNCE_TICKS - 1)) begin
          r_filt <= w_sync;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + W'(1);
        end
      end

      assign dout = r_filt;
    end
  endgenerate

endmodule

// File: rtl/pcileech_perst_ctl.sv
// Conditions board PERST#/presence/power_sw into a clean PERST# for
// the PCIe core, with a guaranteed minimum locally generated low time.
module pcileech_perst_ctl
  import pcileech_perst_ctl_pkg::*;
#(
  parameter int             SYNC_STAGES     = 2,
  parameter int             DEBOUNCE_TICKS  = TICKS_PER_MS,
  parameter int             CNT_W           = 40,
  parameter logic [CNT_W-1:0] PERST_MIN_TICKS = 40'd12_500_000,
  parameter bit             POWER_SW_MODE   = 1'b0,
  parameter logic [CNT_W-1:0] POWER_SW_TIME   = 40'd7_500_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pcie_perst1_n_in,
  input  logic         pcie_perst2_n_in,
  input  logic         pcie_present1_in,
  input  logic         pcie_present2_in,
  input  logic         power_sw_in,
  input  logic         sw_force_perst,
  output logic         pcie_perst_n,
  output logic         pcie_present,
  output perst_state_t state,
  output logic [15:0]  perst_event_cnt
);

  logic [4:0]       w_raw;
  logic [4:0]       w_filt;
  logic             w_host_ok;
  logic             w_pwr;
  logic             w_boot_done;
  logic             w_force_rise;
  logic             w_perst_n;
  perst_state_t     r_state;
  perst_state_t     w_next;
  logic [CNT_W-1:0] r_boot_cnt;
  logic [CNT_W-1:0] r_hold_cnt;
  logic             r_force_q;
  logic             r_perst_n;
  logic             r_present;
  logic [15:0]      r_evt_cnt;

  assign w_raw = {power_sw_in, pcie_present2_in, pcie_present1_in,
                  pcie_perst2_n_in, pcie_perst1_n_in};

  for (genvar g = 0; g < 5; g++) begin : g_deb
    pcileech_perst_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .din  (w_raw[g]),
      .dout (w_filt[g])
    );
  end

  assign w_host_ok    = w_filt[0] & w_filt[1];
  assign w_pwr        = w_filt[4];
  assign w_boot_done  = (r_boot_cnt == POWER_SW_TIME);
  assign w_force_rise = sw_force_perst & ~r_force_q;

  // State register plus the registered outputs and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_RESET;
      r_boot_cnt <= '0;
      r_hold_cnt <= '0;
      r_force_q  <= 1'b0;
      r_perst_n  <= 1'b0;
      r_present  <= 1'b0;
      r_evt_cnt  <= '0;
    end else begin
      r_state   <= w_next;
      r_force_q <= sw_force_perst;
      r_perst_n <= w_perst_n;
      r_present <= w_filt[2] & w_filt[3];
      if (!w_boot_done)
        r_boot_cnt <= r_boot_cnt + CNT_W'(1);
      if (r_state != S_HOLD)
        r_hold_cnt <= '0;
      else
        r_hold_cnt <= r_hold_cnt + CNT_W'(1);
      if (r_perst_n && !w_perst_n && r_evt_cnt != 16'hFFFF)
        r_evt_cnt <= r_evt_cnt + 16'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_RESET:  w_next = S_HOLD;
      S_HOLD:
        if (r_hold_cnt == PERST_MIN_TICKS - CNT_W'(1))
          w_next = (POWER_SW_MODE && !w_boot_done) ? S_DETECT : S_RUN;
      S_DETECT:
        if (w_boot_done)
          w_next = w_pwr ? S_RUN : S_OFF;
      // Losing Thunderbolt outranks a simultaneous force request
      S_RUN:
        if (POWER_SW_MODE && !w_pwr) w_next = S_OFF;
        else if (w_force_rise)       w_next = S_HOLD;
      S_OFF:
        if (w_pwr) w_next = S_HOLD;
      default:  w_next = S_RESET;
    endcase
  end

  always_comb begin
    w_perst_n = 1'b0;
    unique case (r_state)
      S_DETECT, S_RUN: w_perst_n = w_host_ok;
      default:         w_perst_n = 1'b0;
    endcase
  end

  assign pcie_perst_n    = r_perst_n;
  assign pcie_present    = r_present;
  assign state           = r_state;
  assign perst_event_cnt = r_evt_cnt;

endmodule

// File: tb/tb_pcileech_perst_ctl.sv
// Directed bench for pcileech_perst_ctl: one instance ignoring power_sw,
// one monitoring it, sharing the same board inputs.
module tb_pcileech_perst_ctl;
  import pcileech_perst_ctl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic p1, p2, pr1, pr2, pwr, frc;
  logic         perst0, present0, perst1, present1;
  perst_state_t st0, st1;
  logic [15:0]  cnt0, cnt1;
  int errors = 0;
  int checks = 0;
  int lows;

  always #5 clk = ~clk;

  pcileech_perst_ctl #(
    .SYNC_STAGES(2), .DEBOUNCE_TICKS(4), .CNT_W(40),
    .PERST_MIN_TICKS(40'd16), .POWER_SW_MODE(1'b0),
    .POWER_SW_TIME(40'd100)
  ) u0 (
    .clk(clk), .rst(rst),
    .pcie_perst1_n_in(p1), .pcie_perst2_n_in(p2),
    .pcie_present1_in(pr1), .pcie_present2_in(pr2),
    .power_sw_in(pwr), .sw_force_perst(frc),
    .pcie_perst_n(perst0), .pcie_present(present0),
    .state(st0), .perst_event_cnt(cnt0)
  );

  pcileech_perst_ctl #(
    .SYNC_STAGES(2), .DEBOUNCE_TICKS(4), .CNT_W(40),
    .PERST_MIN_TICKS(40'd16), .POWER_SW_MODE(1'b1),
    .POWER_SW_TIME(40'd100)
  ) u1 (
    .clk(clk), .rst(rst),
    .pcie_perst1_n_in(p1), .pcie_perst2_n_in(p2),
    .pcie_present1_in(pr1), .pcie_present2_in(pr2),
    .power_sw_in(pwr), .sw_force_perst(frc),
    .pcie_perst_n(perst1), .pcie_present(present1),
    .state(st1), .perst_event_cnt(cnt1)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; p1 = 1'b1; p2 = 1'b1; pr1 = 1'b1; pr2 = 1'b1;
    pwr = 1'b1; frc = 1'b0;
    step(2);
    chk("rst_state", 16'(st0), 16'(S_RESET));
    chk("rst_perst", 16'(perst0), 16'd0);
    chk("rst_present", 16'(present0), 16'd0);
    chk("rst_cnt", cnt0, 16'd0);

    // Release: S_RESET + 16 cycles of S_HOLD, then S_RUN, output lags by one
    rst = 1'b0;
    step(17);
    chk("boot_state_run", 16'(st0), 16'(S_RUN));
    chk("boot_perst_low", 16'(perst0), 16'd0);
    step(1);
    chk("boot_perst_high", 16'(perst0), 16'd1);
    chk("boot_present", 16'(present0), 16'd1);
    chk("boot_cnt", cnt0, 16'd0);

    // 3-cycle glitch on perst1_n is filtered out
    p1 = 1'b0;
    lows = 0;
    for (int i = 0; i < 13; i++) begin
      if (i == 3) p1 = 1'b1;
      step(1);
      if (perst0 !== 1'b1) lows++;
    end
    chk("glitch_no_drop", 16'(lows), 16'd0);
    chk("glitch_cnt", cnt0, 16'd0);

    // 6-cycle low: output falls on the 7th edge after the raw change
    p1 = 1'b0;
    step(6);
    chk("host_fall_early", 16'(perst0), 16'd1);
    step(1);
    chk("host_fall", 16'(perst0), 16'd0);
    chk("host_state_run", 16'(st0), 16'(S_RUN));
    chk("host_cnt", cnt0, 16'd1);
    p1 = 1'b1;
    step(12);
    chk("host_recover", 16'(perst0), 16'd1);

    // One-cycle force pulse: exactly 16 low cycles
    frc = 1'b1;
    step(1);
    frc = 1'b0;
    lows = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (perst0 === 1'b0) lows++;
    end
    chk("force_low_cycles", 16'(lows), 16'd16);
    chk("force_state_run", 16'(st0), 16'(S_RUN));
    step(1);
    chk("force_release", 16'(perst0), 16'd1);
    chk("force_cnt", cnt0, 16'd2);

    // rst in the middle of S_HOLD restarts the whole sequence
    frc = 1'b1;
    step(1);
    frc = 1'b0;
    step(8);
    chk("midrst_in_hold", 16'(st0), 16'(S_HOLD));
    rst = 1'b1;
    step(1);
    chk("midrst_state", 16'(st0), 16'(S_RESET));
    chk("midrst_perst", 16'(perst0), 16'd0);
    chk("midrst_present", 16'(present0), 16'd0);
    chk("midrst_cnt", cnt0, 16'd0);
    rst = 1'b0;
    step(17);
    chk("midrst_run", 16'(st0), 16'(S_RUN));
    chk("midrst_perst_low", 16'(perst0), 16'd0);
    step(1);
    chk("midrst_perst_high", 16'(perst0), 16'd1);
    chk("midrst_cnt_after", cnt0, 16'd0);

    // Monitoring instance boots with Thunderbolt absent
    pwr = 1'b0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(100);
    chk("m1_detect", 16'(st1), 16'(S_DETECT));
    chk("m1_detect_perst", 16'(perst1), 16'd1);
    step(1);
    chk("m1_off", 16'(st1), 16'(S_OFF));
    chk("m0_ignores_pwr", 16'(st0), 16'(S_RUN));
    step(1);
    chk("m1_off_perst", 16'(perst1), 16'd0);
    chk("m1_off_cnt", cnt1, 16'd1);

    // Thunderbolt arrives: S_HOLD after 7 edges, then a full hold
    pwr = 1'b1;
    step(6);
    chk("m1_still_off", 16'(st1), 16'(S_OFF));
    step(1);
    chk("m1_hold", 16'(st1), 16'(S_HOLD));
    step(15);
    chk("m1_hold_end", 16'(st1), 16'(S_HOLD));
    step(1);
    chk("m1_run", 16'(st1), 16'(S_RUN));
    step(1);
    chk("m1_run_perst", 16'(perst1), 16'd1);

    // power_sw loss and force rise seen together: S_OFF wins
    pwr = 1'b0;
    step(6);
    chk("m1_sim_pre", 16'(st1), 16'(S_RUN));
    frc = 1'b1;
    step(1);
    frc = 1'b0;
    chk("m1_sim_off", 16'(st1), 16'(S_OFF));
    step(1);
    chk("m1_sim_perst", 16'(perst1), 16'd0);
    step(3);
    chk("m1_sim_stays_off", 16'(st1), 16'(S_OFF));
    chk("m1_sim_cnt", cnt1, 16'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
